// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Single-outstanding APB bridge. A one-cycle request from the CPU side is
// decoded against a 64 KB window (upper address half == ADDR_BASE). The low
// 16 KB of that window is split into four 4 KB slave regions. Hits are run
// as a standard SETUP/ACCESS APB transfer. Misses are answered straight from
// IDLE with an error completion. A slave that never raises PREADY is
// abandoned after TIMEOUT ACCESS cycles.
//
// Parameters
//   ADDR_BASE  value of addr[31:16] that maps the peripheral window
//   TIMEOUT    ACCESS cycles to wait for PREADY before reporting an error
//
// Ports
//   PCLK                 clock, all logic on the rising edge
//   PRESET               synchronous active-low reset
//   transfer             one-cycle request pulse (only honoured in IDLE)
//   write/addr/wdata     request attributes, qualified by transfer
//   busy                 high whenever the FSM is not in IDLE
//   ready                one-cycle completion pulse
//   err                  valid with ready: decode miss or timeout
//   rdata                read result, valid with ready
//   PADDR/PWRITE/PWDATA  shared APB address/control/data
//   PENABLE              APB enable (high in ACCESS)
//   PSEL[3:0]            one-hot slave select
//   PRDATA0..3           per-slave read data
//   PREADY0..3           per-slave ready
// ---------------------------------------------------------------------------
module apb_master #(
    parameter logic [15:0] ADDR_BASE = 16'h1000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSEL,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    // The wait counter only has to reach TIMEOUT-1.
    // On the ACCESS cycle where it holds that value the transfer either completes or times out.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      paddr_q, paddr_d;
    logic             pwrite_q, pwrite_d;
    logic             penable_q, penable_d;
    logic [31:0]      pwdata_q, pwdata_d;
    logic [3:0]       psel_q, psel_d;

    logic             addr_hit;
    logic             sel_pready;
    logic [31:0]      sel_prdata;

    assign addr_hit = (addr[31:16] == ADDR_BASE) && (addr[15:14] == 2'b00);

    // Pick out the response of the slave we are talking to.
    // PADDR is held for the whole transfer, so its slave bits are a stable index.
    // The other three slaves never influence the result.
    always_comb begin
        sel_pready = 1'b0;
        sel_prdata = 32'h0;
        case (paddr_q[13:12])
            2'd0: begin sel_pready = PREADY0; sel_prdata = PRDATA0; end
            2'd1: begin sel_pready = PREADY1; sel_prdata = PRDATA1; end
            2'd2: begin sel_pready = PREADY2; sel_prdata = PRDATA2; end
            default: begin sel_pready = PREADY3; sel_prdata = PRDATA3; end
        endcase
    end

    // Next-state and next-output computation for the whole bridge.
    // Every output is a flop, so everything the outside world sees in the following cycle is decided here.
    // ready/err default low, which makes them one-cycle pulses.
    // The address/data bus defaults to holding, which keeps it stable through SETUP/ACCESS and retained in IDLE.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        penable_d  = penable_q;
        pwdata_d   = pwdata_q;
        psel_d     = psel_q;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (addr_hit) begin
                        paddr_d    = addr;
                        pwrite_d   = write;
                        pwdata_d   = wdata;
                        psel_d     = 4'b0001 << addr[13:12];
                        penable_d  = 1'b0;
                        wait_cnt_d = '0;
                        state_d    = SETUP;
                    end else begin
                        // A decode miss never touches the bus; it is answered directly from IDLE.
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end

            ACCESS: begin
                if (sel_pready) begin
                    if (!pwrite_q) begin
                        rdata_d = sel_prdata;
                    end
                    ready_d   = 1'b1;
                    err_d     = 1'b0;
                    psel_d    = 4'b0000;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = 32'h0;
                    psel_d    = 4'b0000;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                psel_d    = 4'b0000;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        // busy is registered from the next state, so it drops in the same cycle ready rises.
        busy_d = (state_d != IDLE);
    end

    // State register for the FSM and all of its registered outputs.
    // Reset is synchronous and active-low.
    // A reset landing mid-transfer simply wipes everything, so no completion pulse is ever produced for it.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            paddr_q    <= 32'h0;
            pwrite_q   <= 1'b0;
            penable_q  <= 1'b0;
            pwdata_q   <= 32'h0;
            psel_q     <= 4'b0000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            penable_q  <= penable_d;
            pwdata_q   <= pwdata_d;
            psel_q     <= psel_d;
        end
    end

    assign busy    = busy_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = penable_q;
    assign PWDATA  = pwdata_q;
    assign PSEL    = psel_q;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Self-checking bench for apb_master. A table of single transfers is run
// through applyStimulus, covering hits on every slave, wait states, decode
// misses, the last-cycle PREADY boundary and a full timeout. Hand-written
// sequences then cover reset, back-to-back/ignored requests and reset
// arriving in the middle of ACCESS. A small slave responder raises PREADY
// of the selected slave a programmable number of ACCESS cycles late.
// Unselected slaves always drive PREADY=1 and junk PRDATA.
// ---------------------------------------------------------------------------
module tb_apb_master;

    localparam int NEVER = 1000;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          slave;
        int          wait_cyc;
        logic [31:0] prdata;
        logic [3:0]  exp_psel;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    int          checks_total  = 0;
    int          checks_passed = 0;

    int          wait_cfg   = 0;
    int          cur_slave  = 0;
    logic [31:0] prdata_cfg = 32'h0;
    int          acc_cnt    = 0;
    logic        sel_ready  = 1'b0;

    logic [31:0] last_paddr;
    logic [31:0] last_pwdata;
    logic        last_pwrite;

    vec_t vecs[9];

    apb_master #(
        .ADDR_BASE(16'h1000),
        .TIMEOUT  (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .transfer(transfer),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .ready   (ready),
        .err     (err),
        .rdata   (rdata),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PWDATA  (PWDATA),
        .PSEL    (PSEL),
        .PRDATA0 (PRDATA0),
        .PRDATA1 (PRDATA1),
        .PRDATA2 (PRDATA2),
        .PRDATA3 (PRDATA3),
        .PREADY0 (PREADY0),
        .PREADY1 (PREADY1),
        .PREADY2 (PREADY2),
        .PREADY3 (PREADY3)
    );

    always #5 PCLK = ~PCLK;

    // Slave responder: count ACCESS cycles of the current transfer.
    // Raise the selected slave's PREADY once wait_cfg wait cycles have passed.
    always @(negedge PCLK) begin
        if (PENABLE && (PSEL != 4'b0000)) acc_cnt = acc_cnt + 1;
        else                              acc_cnt = 0;
        sel_ready = (acc_cnt > wait_cfg);
    end

    // Unselected slaves shout ready with junk data so a wrong mux is exposed.
    assign PREADY0 = PSEL[0] ? sel_ready : 1'b1;
    assign PREADY1 = PSEL[1] ? sel_ready : 1'b1;
    assign PREADY2 = PSEL[2] ? sel_ready : 1'b1;
    assign PREADY3 = PSEL[3] ? sel_ready : 1'b1;
    assign PRDATA0 = (cur_slave == 0) ? prdata_cfg : 32'hBAD0_0000;
    assign PRDATA1 = (cur_slave == 1) ? prdata_cfg : 32'hBAD0_0001;
    assign PRDATA2 = (cur_slave == 2) ? prdata_cfg : 32'hBAD0_0002;
    assign PRDATA3 = (cur_slave == 3) ? prdata_cfg : 32'hBAD0_0003;

    // One comparison: bump the counters and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total = checks_total + 1;
        if (actual === expected) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Run one table entry: pulse transfer, follow the transfer to its ready pulse and check everything around it.
    task automatic applyStimulus(input int idx, input vec_t v);
        int   lat;
        logic stable;
        logic hit;
        hit = (v.exp_psel != 4'b0000);
        if (hit) begin
            last_paddr  = v.addr;
            last_pwdata = v.wdata;
            last_pwrite = v.wr;
        end
        wait_cfg   = v.wait_cyc;
        cur_slave  = v.slave;
        prdata_cfg = v.prdata;

        @(negedge PCLK);
        transfer = 1'b1;
        write    = v.wr;
        addr     = v.addr;
        wdata    = v.wdata;
        lat      = 0;
        stable   = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge PCLK);
            if (cyc == 1) begin
                transfer = 1'b0;
                checkOutput($sformatf("v%0d_first_psel", idx), {28'h0, PSEL}, {28'h0, v.exp_psel});
                checkOutput($sformatf("v%0d_first_penable", idx), {31'h0, PENABLE}, 32'h0);
                checkOutput($sformatf("v%0d_paddr", idx), PADDR, last_paddr);
            end
            if (busy === 1'b1) begin
                if (PADDR !== last_paddr || PWDATA !== last_pwdata ||
                    PWRITE !== last_pwrite || PSEL !== v.exp_psel) stable = 1'b0;
            end
            if (ready === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        checkOutput($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        checkOutput($sformatf("v%0d_err", idx), {31'h0, err}, {31'h0, v.exp_err});
        checkOutput($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
        checkOutput($sformatf("v%0d_done_psel", idx), {28'h0, PSEL}, 32'h0);
        checkOutput($sformatf("v%0d_done_penable", idx), {31'h0, PENABLE}, 32'h0);
        checkOutput($sformatf("v%0d_done_busy", idx), {31'h0, busy}, 32'h0);
        checkOutput($sformatf("v%0d_pwdata", idx), PWDATA, last_pwdata);
        checkOutput($sformatf("v%0d_bus_stable", idx), {31'h0, stable}, 32'h1);
        @(negedge PCLK);
        checkOutput($sformatf("v%0d_ready_drop", idx), {31'h0, ready}, 32'h0);
        checkOutput($sformatf("v%0d_err_drop", idx), {31'h0, err}, 32'h0);
    endtask

    initial begin
        int extra_ready;

        // Latency counts cycles after the transfer cycle: hit = 3 + waits, miss = 1, timeout = 2 + 16.
        //            wr    addr           wdata          sl wait   prdata         psel     rdata          err lat
        vecs[0] = '{1'b1, 32'h1000_2004, 32'hDEAD_BEEF, 2, 0,     32'h0,         4'b0100, 32'h0000_0000, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h1000_1008, 32'h0,         1, 1,     32'h1234_5678, 4'b0010, 32'h1234_5678, 1'b0, 4};
        vecs[2] = '{1'b1, 32'h1000_0010, 32'h0BAD_F00D, 0, 2,     32'h0,         4'b0001, 32'h1234_5678, 1'b0, 5};
        vecs[3] = '{1'b0, 32'h2000_0000, 32'h0,         0, 0,     32'h0,         4'b0000, 32'h0000_0000, 1'b1, 1};
        vecs[4] = '{1'b0, 32'h1000_4000, 32'h0,         0, 0,     32'h0,         4'b0000, 32'h0000_0000, 1'b1, 1};
        vecs[5] = '{1'b0, 32'h1000_3FFC, 32'h5555_0000, 3, 0,     32'hA5A5_5A5A, 4'b1000, 32'hA5A5_5A5A, 1'b0, 3};
        vecs[6] = '{1'b0, 32'h1000_3000, 32'h0,         3, NEVER, 32'h7777_7777, 4'b1000, 32'h0000_0000, 1'b1, 18};
        vecs[7] = '{1'b0, 32'h1000_0000, 32'h0,         0, 15,    32'h600D_CAFE, 4'b0001, 32'h600D_CAFE, 1'b0, 18};
        vecs[8] = '{1'b1, 32'h1001_0000, 32'hFFFF_0000, 0, 0,     32'h0,         4'b0000, 32'h0000_0000, 1'b1, 1};

        // Reset with a hit request pending: the request must be ignored.
        PRESET   = 1'b0;
        transfer = 1'b1;
        write    = 1'b1;
        addr     = 32'h1000_2000;
        wdata    = 32'h1111_1111;
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_ready", {31'h0, ready}, 32'h0);
        checkOutput("rst_err", {31'h0, err}, 32'h0);
        checkOutput("rst_psel", {28'h0, PSEL}, 32'h0);
        checkOutput("rst_penable", {31'h0, PENABLE}, 32'h0);
        checkOutput("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        checkOutput("rst_paddr", PADDR, 32'h0);
        checkOutput("rst_pwdata", PWDATA, 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        PRESET      = 1'b1;
        transfer    = 1'b0;
        last_paddr  = 32'h0;
        last_pwdata = 32'h0;
        last_pwrite = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Back-to-back: a request during ACCESS is dropped.
        // A request in the ready cycle starts SETUP straight away.
        wait_cfg   = 1;
        cur_slave  = 1;
        prdata_cfg = 32'hCAFE_F00D;
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000; wdata = 32'h0;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        checkOutput("b2b_busy_access", {31'h0, busy}, 32'h1);
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_3000; wdata = 32'hFFFF_FFFF;
        @(negedge PCLK);
        transfer = 1'b0;
        checkOutput("b2b_ignored_paddr", PADDR, 32'h1000_1000);
        checkOutput("b2b_ignored_psel", {28'h0, PSEL}, 32'h2);
        checkOutput("b2b_ready_early", {31'h0, ready}, 32'h0);
        @(negedge PCLK);
        checkOutput("b2b_ready1", {31'h0, ready}, 32'h1);
        checkOutput("b2b_rdata1", rdata, 32'hCAFE_F00D);
        checkOutput("b2b_busy_ready", {31'h0, busy}, 32'h0);
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_2008; wdata = 32'h1122_3344;
        cur_slave = 2;
        @(negedge PCLK);
        transfer = 1'b0;
        checkOutput("b2b_setup_busy", {31'h0, busy}, 32'h1);
        checkOutput("b2b_setup_psel", {28'h0, PSEL}, 32'h4);
        checkOutput("b2b_setup_penable", {31'h0, PENABLE}, 32'h0);
        checkOutput("b2b_setup_paddr", PADDR, 32'h1000_2008);
        checkOutput("b2b_setup_pwdata", PWDATA, 32'h1122_3344);
        checkOutput("b2b_setup_ready", {31'h0, ready}, 32'h0);
        @(negedge PCLK);
        checkOutput("b2b_access_penable", {31'h0, PENABLE}, 32'h1);
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("b2b_ready2", {31'h0, ready}, 32'h1);
        checkOutput("b2b_err2", {31'h0, err}, 32'h0);
        checkOutput("b2b_rdata2", rdata, 32'hCAFE_F00D);
        extra_ready = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge PCLK);
            if (ready === 1'b1) extra_ready = extra_ready + 1;
        end
        checkOutput("b2b_extra_ready", extra_ready, 32'h0);

        // Reset arriving during ACCESS aborts the transfer silently.
        wait_cfg   = NEVER;
        cur_slave  = 3;
        prdata_cfg = 32'h9999_9999;
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3010; wdata = 32'h0;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        checkOutput("mid_rst_penable_before", {31'h0, PENABLE}, 32'h1);
        PRESET = 1'b0;
        @(negedge PCLK);
        checkOutput("mid_rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("mid_rst_ready", {31'h0, ready}, 32'h0);
        checkOutput("mid_rst_err", {31'h0, err}, 32'h0);
        checkOutput("mid_rst_psel", {28'h0, PSEL}, 32'h0);
        checkOutput("mid_rst_penable", {31'h0, PENABLE}, 32'h0);
        checkOutput("mid_rst_paddr", PADDR, 32'h0);
        checkOutput("mid_rst_rdata", rdata, 32'h0);
        PRESET = 1'b1;
        extra_ready = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge PCLK);
            if (ready === 1'b1 || busy === 1'b1) extra_ready = extra_ready + 1;
        end
        checkOutput("mid_rst_no_ready", extra_ready, 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
